// File: rtl/tpdf_dither.sv
// Multichannel TPDF dither and word-length reducer. It drives an external per-channel
// randomizer, adds two signed draws to each sample, then rounds and saturates it.
`timescale 1ns/1ps
module tpdf_dither #(
  parameter int          NR_CHANNELS  = 2,
  parameter int          INPUT_WIDTH  = 24,
  parameter int          OUTPUT_WIDTH = 16,
  parameter int          RNDM_WIDTH   = 32,
  parameter logic [31:0] SEED         = 32'hACE12468,
  localparam int         CH_W         = (NR_CHANNELS > 1) ? $clog2(NR_CHANNELS) : 1
) (
  input  logic                    clk,
  input  logic                    rst_n,
  input  logic                    dither_enable,
  input  logic [INPUT_WIDTH-1:0]  s_dither_d,
  input  logic [CH_W-1:0]         s_dither_ch,
  input  logic                    s_dither_dv,
  output logic                    s_dither_dr,
  output logic [OUTPUT_WIDTH-1:0] m_dither_d,
  output logic [CH_W-1:0]         m_dither_ch,
  output logic                    m_dither_dv,
  input  logic                    m_dither_dr,
  output logic [CH_W-1:0]         rndm_ch,
  output logic [RNDM_WIDTH-1:0]   rndm_seed,
  output logic                    rndm_init,
  input  logic [RNDM_WIDTH-1:0]   rndm_out,
  output logic                    rndm_ready
);

  localparam int D  = INPUT_WIDTH - OUTPUT_WIDTH;
  localparam int SW = INPUT_WIDTH + 2;
  localparam logic [RNDM_WIDTH-1:0] SEED_R = RNDM_WIDTH'(SEED);
  localparam logic [CH_W:0]         NR_C   = (CH_W+1)'(NR_CHANNELS);
  localparam logic signed [SW-1:0]  HALF   = SW'(64'sd1 <<< (D-1));
  localparam logic signed [SW-1:0]  MAX_S  = SW'((64'sd1 <<< (OUTPUT_WIDTH-1)) - 64'sd1);
  localparam logic signed [SW-1:0]  MIN_S  = ~MAX_S;

  typedef enum logic [2:0] {
    ST_SEED, ST_IDLE, ST_RND1, ST_RND2, ST_RND3, ST_SUM, ST_OUT
  } state_t;

  state_t                  state_q, state_d;
  logic [CH_W:0]           cnt_q, cnt_d;
  logic [INPUT_WIDTH-1:0]  x_q, x_d;
  logic [CH_W-1:0]         ch_q, ch_d;
  logic [D-1:0]            r1_q, r1_d, r2_q, r2_d;
  logic                    s_dr_q, s_dr_d;
  logic [OUTPUT_WIDTH-1:0] m_d_q, m_d_d;
  logic [CH_W-1:0]         m_ch_q, m_ch_d;
  logic                    m_dv_q, m_dv_d;
  logic [CH_W-1:0]         rndm_ch_q, rndm_ch_d;
  logic [RNDM_WIDTH-1:0]   rndm_seed_q, rndm_seed_d;
  logic                    rndm_init_q, rndm_init_d;
  logic                    rndm_ready_q, rndm_ready_d;

  logic signed [SW-1:0]    sum_s, shr_s;
  logic [OUTPUT_WIDTH-1:0] sat_y;
  logic [D-1:0]            rnd_top;
  logic                    in_range;
  logic                    rndm_unused;

  // Only the top D randomizer bits feed the dither; the rest are deliberately ignored.
  assign rnd_top     = rndm_out[RNDM_WIDTH-1 -: D];
  assign rndm_unused = ^rndm_out;
  assign in_range    = {1'b0, s_dither_ch} < NR_C;

  always_comb begin
    sum_s = SW'($signed(x_q)) + SW'($signed(r1_q)) + SW'($signed(r2_q)) + HALF;
    shr_s = sum_s >>> D;
    if (shr_s > MAX_S)      sat_y = MAX_S[OUTPUT_WIDTH-1:0];
    else if (shr_s < MIN_S) sat_y = MIN_S[OUTPUT_WIDTH-1:0];
    else                    sat_y = shr_s[OUTPUT_WIDTH-1:0];
  end

  // Both streams: a beat transfers on a rising edge where valid and ready are both high;
  // the producer keeps valid and data stable until that edge. All outputs are registered.
  always_comb begin
    state_d      = state_q;
    cnt_d        = cnt_q;
    x_d          = x_q;
    ch_d         = ch_q;
    r1_d         = r1_q;
    r2_d         = r2_q;
    s_dr_d       = s_dr_q;
    m_d_d        = m_d_q;
    m_ch_d       = m_ch_q;
    m_dv_d       = m_dv_q;
    rndm_ch_d    = rndm_ch_q;
    rndm_seed_d  = rndm_seed_q;
    rndm_init_d  = 1'b0;
    rndm_ready_d = 1'b0;
    case (state_q)
      ST_SEED: begin
        if (cnt_q == NR_C) begin
          state_d = ST_IDLE;
          s_dr_d  = 1'b1;
        end else begin
          rndm_init_d = 1'b1;
          rndm_ch_d   = cnt_q[CH_W-1:0];
          rndm_seed_d = SEED_R + RNDM_WIDTH'(cnt_q);
          cnt_d       = cnt_q + (CH_W+1)'(1);
        end
      end
      ST_IDLE: begin
        if (s_dither_dv && s_dr_q) begin
          s_dr_d = 1'b0;
          x_d    = s_dither_d;
          ch_d   = s_dither_ch;
          if (dither_enable && in_range) begin
            state_d      = ST_RND1;
            rndm_ready_d = 1'b1;
            rndm_ch_d    = s_dither_ch;
          end else begin
            r1_d    = '0;
            r2_d    = '0;
            state_d = ST_SUM;
          end
        end
      end
      ST_RND1: begin
        rndm_ready_d = 1'b1;
        state_d      = ST_RND2;
      end
      // Each draw appears on rndm_out one cycle after its request cycle.
      ST_RND2: begin
        r1_d    = rnd_top;
        state_d = ST_RND3;
      end
      ST_RND3: begin
        r2_d    = rnd_top;
        state_d = ST_SUM;
      end
      ST_SUM: begin
        m_d_d   = sat_y;
        m_ch_d  = ch_q;
        m_dv_d  = 1'b1;
        state_d = ST_OUT;
      end
      ST_OUT: begin
        if (m_dither_dr) begin
          m_dv_d  = 1'b0;
          s_dr_d  = 1'b1;
          state_d = ST_IDLE;
        end
      end
      default: state_d = ST_SEED;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q      <= ST_SEED;
      cnt_q        <= '0;
      x_q          <= '0;
      ch_q         <= '0;
      r1_q         <= '0;
      r2_q         <= '0;
      s_dr_q       <= 1'b0;
      m_d_q        <= '0;
      m_ch_q       <= '0;
      m_dv_q       <= 1'b0;
      rndm_ch_q    <= '0;
      rndm_seed_q  <= '0;
      rndm_init_q  <= 1'b0;
      rndm_ready_q <= 1'b0;
    end else begin
      state_q      <= state_d;
      cnt_q        <= cnt_d;
      x_q          <= x_d;
      ch_q         <= ch_d;
      r1_q         <= r1_d;
      r2_q         <= r2_d;
      s_dr_q       <= s_dr_d;
      m_d_q        <= m_d_d;
      m_ch_q       <= m_ch_d;
      m_dv_q       <= m_dv_d;
      rndm_ch_q    <= rndm_ch_d;
      rndm_seed_q  <= rndm_seed_d;
      rndm_init_q  <= rndm_init_d;
      rndm_ready_q <= rndm_ready_d;
    end
  end

  assign s_dither_dr = s_dr_q;
  assign m_dither_d  = m_d_q;
  assign m_dither_ch = m_ch_q;
  assign m_dither_dv = m_dv_q;
  assign rndm_ch     = rndm_ch_q;
  assign rndm_seed   = rndm_seed_q;
  assign rndm_init   = rndm_init_q;
  assign rndm_ready  = rndm_ready_q;

endmodule

// File: tb/tb_tpdf_dither.sv
// Bench for tpdf_dither with three channels (so channel 3 is out of range), a
// stand-in xorshift32 randomizer and an independent model of the expected outputs.
`timescale 1ns/1ps
module tb_tpdf_dither;
  localparam int NR = 3;
  localparam int IW = 24;
  localparam int OW = 16;
  localparam int RW = 32;
  localparam int CW = 2;
  localparam logic [31:0] SEED = 32'hACE12468;

  logic clk, rst_n, dither_enable;
  logic [IW-1:0] s_dither_d;
  logic [CW-1:0] s_dither_ch, m_dither_ch, rndm_ch;
  logic s_dither_dv, s_dither_dr, m_dither_dv, m_dither_dr, rndm_init, rndm_ready;
  logic [OW-1:0] m_dither_d;
  logic [RW-1:0] rndm_seed;
  logic [RW-1:0] rndm_out = '0;

  tpdf_dither #(.NR_CHANNELS(NR), .INPUT_WIDTH(IW), .OUTPUT_WIDTH(OW),
                .RNDM_WIDTH(RW), .SEED(SEED)) dut (
    .clk(clk), .rst_n(rst_n), .dither_enable(dither_enable),
    .s_dither_d(s_dither_d), .s_dither_ch(s_dither_ch), .s_dither_dv(s_dither_dv),
    .s_dither_dr(s_dither_dr), .m_dither_d(m_dither_d), .m_dither_ch(m_dither_ch),
    .m_dither_dv(m_dither_dv), .m_dither_dr(m_dither_dr), .rndm_ch(rndm_ch),
    .rndm_seed(rndm_seed), .rndm_init(rndm_init), .rndm_out(rndm_out),
    .rndm_ready(rndm_ready));

  // clock / reset
  initial clk = 1'b0;
  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;
  logic [CW+OW-1:0] exp_q[$];
  logic [IW-1:0]    x_q[$];
  logic [31:0]      m_st [NR];
  logic [31:0]      rnd_st [4];
  int dr_mode = 0;
  int viol = 0;
  bit hist_on = 0;
  int hist [3];
  int hist_bad = 0;

  function automatic logic [31:0] xs(input logic [31:0] v);
    logic [31:0] t;
    t = v;
    t = t ^ (t << 13);
    t = t ^ (t >> 17);
    t = t ^ (t << 5);
    return t;
  endfunction

  function automatic logic [OW-1:0] model_y(input logic [IW-1:0] x, input logic [31:0] a,
                                            input logic [31:0] b, input bit dith);
    longint s, y;
    s = longint'($signed(x));
    if (dith) s = s + longint'($signed(a[31:24])) + longint'($signed(b[31:24]));
    s = s + 128;
    y = s >>> 8;
    if (y > 32767) y = 32767;
    if (y < -32768) y = -32768;
    return y[OW-1:0];
  endfunction

  task automatic reset_model();
    for (int n = 0; n < NR; n++) m_st[n] = SEED + n;
  endtask

  task automatic check(input string name, input longint act, input longint exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%0h expected=%0h at %0t", name, act, exp, $time);
    end
  endtask

  // stand-in randomizer: seed on init, one xorshift step per ready cycle
  always @(posedge clk) begin
    if (rndm_init) rnd_st[rndm_ch] <= rndm_seed;
    if (rndm_ready) begin
      rnd_st[rndm_ch] <= xs(rnd_st[rndm_ch]);
      rndm_out        <= xs(rnd_st[rndm_ch]);
    end
  end

  // output ready driver
  initial begin
    m_dither_dr = 1'b1;
    forever begin
      @(posedge clk);
      #2;
      case (dr_mode)
        0: m_dither_dr = 1'b1;
        1: m_dither_dr = ($urandom_range(0, 3) != 0);
        default: m_dither_dr = 1'b0;
      endcase
    end
  end

  // scoreboard
  always @(negedge clk) begin
    logic [CW+OW-1:0] e;
    logic [IW-1:0] xv;
    longint dev;
    int yi;
    if (rndm_init && rndm_ready) viol++;
    if (rst_n && m_dither_dv && m_dither_dr) begin
      if (exp_q.size() == 0) begin
        checks++;
        errors++;
        $display("FAIL unexpected_output actual=%0h required=none at %0t", m_dither_d, $time);
      end else begin
        e  = exp_q.pop_front();
        xv = x_q.pop_front();
        check("out_ch_d", {m_dither_ch, m_dither_d}, e);
        dev = 256 * longint'($signed(m_dither_d)) - longint'($signed(xv));
        if (dev < 0) dev = -dev;
        checks++;
        if (dev > 384) begin
          errors++;
          $display("FAIL err_bound actual=%0d required<=384 x=%0h y=%0h", dev, xv, m_dither_d);
        end
        if (hist_on) begin
          yi = int'($signed(m_dither_d));
          if (yi >= -1 && yi <= 1) hist[yi+1]++;
          else hist_bad++;
        end
      end
    end
  end

  // driver: present a sample, wait for acceptance, push the expectation
  task automatic send(input logic [IW-1:0] x, input logic [CW-1:0] ch, input logic en,
                      input bit use_fixed, input logic [OW-1:0] fixed_y);
    int n;
    bit dith;
    logic [31:0] a, b;
    s_dither_d = x; s_dither_ch = ch; dither_enable = en; s_dither_dv = 1'b1;
    n = 0;
    while (!s_dither_dr && n < 500) begin
      @(posedge clk); #1; n++;
    end
    if (!s_dither_dr) begin
      checks++; errors++;
      $display("FAIL accept_timeout actual=no_ready required=ready at %0t", $time);
      s_dither_dv = 1'b0;
      return;
    end
    @(posedge clk);
    dith = en && (ch < NR);
    a = '0; b = '0;
    if (dith) begin
      a = xs(m_st[ch]);
      b = xs(a);
      m_st[ch] = b;
    end
    exp_q.push_back({ch, use_fixed ? fixed_y : model_y(x, a, b, dith)});
    x_q.push_back(x);
    #1;
    s_dither_dv = 1'b0;
    s_dither_d  = IW'($urandom);
  endtask

  task automatic measure(output int lat, output int rdy);
    lat = 0; rdy = 0;
    while (!m_dither_dv && lat < 20) begin
      if (rndm_ready) rdy++;
      @(posedge clk); #1; lat++;
    end
  endtask

  task automatic seed_check();
    for (int n = 0; n < NR; n++) begin
      @(posedge clk); #1;
      check("seed_init", rndm_init, 1);
      check("seed_ch", rndm_ch, n);
      check("seed_val", rndm_seed, SEED + n);
      check("seed_no_ready", {rndm_ready, s_dither_dr}, 0);
    end
    @(posedge clk); #1;
    check("seed_done_init", rndm_init, 0);
    check("seed_done_dr", s_dither_dr, 1);
  endtask

  task automatic drain();
    int n;
    n = 0;
    while (exp_q.size() != 0 && n < 300) begin
      @(posedge clk); #1; n++;
    end
    check("drain_pending", exp_q.size(), 0);
  endtask

  function automatic longint all_outs();
    return {s_dither_dr, m_dither_d, m_dither_ch, m_dither_dv, rndm_ch, rndm_init, rndm_ready}
           | longint'(rndm_seed);
  endfunction

  typedef struct {
    logic [IW-1:0] x;
    logic [CW-1:0] ch;
    logic          en;
    logic [OW-1:0] y;
  } vec_t;
  vec_t tbl [12];

  initial begin
    int lat, rdy;
    logic [OW-1:0] hd;
    logic [CW-1:0] hc;
    rst_n = 1'b0; dither_enable = 1'b0; s_dither_d = '0; s_dither_ch = '0; s_dither_dv = 1'b0;
    hist[0] = 0; hist[1] = 0; hist[2] = 0;
    reset_model();
    tbl[0]  = '{24'h001280, 2'd0, 1'b0, 16'h0013};
    tbl[1]  = '{24'h00127F, 2'd1, 1'b0, 16'h0012};
    tbl[2]  = '{24'h7FFF80, 2'd2, 1'b0, 16'h7FFF};
    tbl[3]  = '{24'h800000, 2'd0, 1'b0, 16'h8000};
    tbl[4]  = '{24'hFFFF80, 2'd1, 1'b0, 16'h0000};
    tbl[5]  = '{24'hFFFF7F, 2'd2, 1'b0, 16'hFFFF};
    tbl[6]  = '{24'h7FFFFF, 2'd0, 1'b0, 16'h7FFF};
    tbl[7]  = '{24'h7FFF7F, 2'd1, 1'b0, 16'h7FFF};
    tbl[8]  = '{24'h001280, 2'd3, 1'b1, 16'h0013};
    tbl[9]  = '{24'h800000, 2'd3, 1'b1, 16'h8000};
    tbl[10] = '{24'h000000, 2'd0, 1'b0, 16'h0000};
    tbl[11] = '{24'hFFFF00, 2'd1, 1'b0, 16'hFFFF};

    #23;
    @(negedge clk);
    check("reset_outputs", all_outs(), 0);
    rst_n = 1'b1;
    seed_check();

    // undithered and out-of-range vectors
    for (int i = 0; i < 12; i++) begin
      send(tbl[i].x, tbl[i].ch, tbl[i].en, 1'b1, tbl[i].y);
      measure(lat, rdy);
      check("tbl_latency", lat, 1);
      check("tbl_ready_cycles", rdy, 0);
    end
    drain();

    // dithered latency; enable dropped right after acceptance must not matter
    send(24'h123456, 2'd0, 1'b1, 1'b0, '0);
    dither_enable = 1'b0;
    measure(lat, rdy);
    check("dith_latency", lat, 4);
    check("dith_ready_cycles", rdy, 2);
    drain();

    // output stall
    dr_mode = 2;
    @(posedge clk); #1;
    send(24'hABCDEF, 2'd1, 1'b1, 1'b0, '0);
    measure(lat, rdy);
    check("stall_latency", lat, 4);
    hd = m_dither_d; hc = m_dither_ch;
    for (int i = 0; i < 10; i++) begin
      @(posedge clk); #1;
      check("stall_d", m_dither_d, hd);
      check("stall_ch", m_dither_ch, hc);
      check("stall_dv_dr_rdy", {m_dither_dv, s_dither_dr, rndm_ready}, 3'b100);
    end
    dr_mode = 0;
    drain();

    // reset while waiting on the first draw
    send(24'h0F0F0F, 2'd0, 1'b1, 1'b0, '0);
    @(posedge clk); #3;
    rst_n = 1'b0;
    #1;
    check("midreset_outputs", all_outs(), 0);
    exp_q.delete(); x_q.delete();
    reset_model();
    #20;
    @(negedge clk);
    rst_n = 1'b1;
    seed_check();
    send(24'h0F0F0F, 2'd0, 1'b1, 1'b0, '0);
    measure(lat, rdy);
    check("post_reset_latency", lat, 4);
    drain();

    // random dithered samples with random output stalls
    dr_mode = 1;
    for (int i = 0; i < 3000; i++) send(IW'($urandom), CW'(i % NR), 1'b1, 1'b0, '0);
    drain();

    // zero-input stream histogram
    hist_on = 1;
    for (int i = 0; i < 600; i++) send(24'h000000, CW'(i % NR), 1'b1, 1'b0, '0);
    drain();
    hist_on = 0;
    dr_mode = 0;
    check("hist_out_of_set", hist_bad, 0);
    checks++;
    if (!(hist[1] > hist[0] && hist[1] > hist[2] && hist[0] > 0 && hist[2] > 0)) begin
      errors++;
      $display("FAIL hist_shape actual=%0d/%0d/%0d required=triangular", hist[0], hist[1], hist[2]);
    end
    check("init_ready_overlap", viol, 0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

  initial begin
    #3000000;
    $display("FAIL watchdog actual=timeout required=finish");
    $fatal(1, "watchdog");
  end

endmodule
